fir_requant_decim: RTL and testbench

- Sits directly downstream of the 24-tap direct-form FIR.
- Takes the FIR's 32-bit signed full-precision sum and decimates it by DECIM.
- Rounds away SHIFT fractional bits and saturates to OUT_W bits.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready output, so a slower consumer (DAC/serializer/bus) can drain them without stalling the free-running filter.

---
 rtl/fir_requant_decim_if.sv | 22 ++
 rtl/fir_requant_decim.sv | 173 +++++++++++++++++
 tb/tb_fir_requant_decim.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_requant_decim_if.sv
// Streaming interface for fir_requant_decim: FIR sample input (no backpressure)
// and valid/ready requantized output. The "slave" modport is the block's view.
interface fir_requant_decim_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_requant_decim.sv
// fir_requant_decim: decimate the full-precision FIR sum by DECIM, round away
// SHIFT fractional bits, saturate to OUT_W and buffer in a FWFT output FIFO.
// Pipeline: accept register -> rounding register -> clamp + FIFO write.
// Optional macro FIR_REQUANT_CONV_ROUND_EN selects round-half-to-even
// instead of round-half-up; latency is identical in both builds.
module fir_requant_decim #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  fir_requant_decim_if.slave               bus,
  input  logic                             clr_flags,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             sat_flag,
  output logic                             ovf_flag
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int XW    = IN_W + 1;

  localparam logic signed [XW-1:0] HALF = {{(XW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`ifdef FIR_REQUANT_CONV_ROUND_EN
  localparam logic signed [XW-1:0] FRAC_MASK = (HALF << 1) - XW'(1);
`endif

  // ---------------------------------------------------------------- decimation
  logic [CNT_W-1:0] dec_cnt;
  logic             keep;

  assign keep = bus.in_valid && (dec_cnt == '0);

  // Decimation phase counter: advances on valid inputs only, wraps at DECIM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (bus.in_valid) begin
      if (dec_cnt == CNT_W'(DECIM - 1)) dec_cnt <= '0;
      else                              dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------- stage 0
  logic                   s0_valid;
  logic signed [IN_W-1:0] s0_data;

  // Capture the kept sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= keep;
      if (keep) s0_data <= bus.in_data;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd_sum;
  logic signed [XW-1:0] rnd;

  // Round: one guard bit above the input keeps the +HALF from wrapping.
  always_comb begin
    ext     = {s0_data[IN_W-1], s0_data};
    rnd_sum = ext + HALF;
    rnd     = rnd_sum >>> SHIFT;
`ifdef FIR_REQUANT_CONV_ROUND_EN
    // An exact tie rounded up to an odd value steps back to the even neighbour.
    if (((ext & FRAC_MASK) == HALF) && rnd[0]) rnd = rnd - XW'(1);
`endif
  end

  logic                 s1_valid;
  logic signed [XW-1:0] s1_data;

  // Register the rounded value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) s1_data <= rnd;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic             over;
  logic             under;
  logic [OUT_W-1:0] wr_val;

  // Saturate the rounded value to the output range.
  always_comb begin
    over   = s1_data > MAXV;
    under  = s1_data < MINV;
    wr_val = s1_data[OUT_W-1:0];
    if (over)  wr_val = OUT_MAX;
    if (under) wr_val = OUT_MIN;
  end

  // ---------------------------------------------------------------- FIFO
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             sat_set;

  // FIFO control: a write into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    empty   = (count == '0);
    full    = (count == LW'(FIFO_DEPTH));
    pop     = !empty && bus.out_ready;
    push    = s1_valid && (!full || pop);
    ovf_set = s1_valid && full && !pop;
    sat_set = s1_valid && (over || under);
  end

  // Storage array; occupancy is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_val;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  // Sticky flags; a set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (sat_set)        sat_flag <= 1'b1;
      else if (clr_flags) sat_flag <= 1'b0;
      if (ovf_set)        ovf_flag <= 1'b1;
      else if (clr_flags) ovf_flag <= 1'b0;
    end
  end

  // First-word fall-through head; zero while empty.
  always_comb begin
    bus.out_valid = !empty;
    bus.out_data  = '0;
    if (!empty) bus.out_data = mem[rd_ptr];
    fifo_level    = count;
  end

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: two instances (DECIM=4 and DECIM=1) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_fir_requant_decim;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 8;
`ifdef FIR_REQUANT_CONV_ROUND_EN
  localparam bit CONV = 1'b1;
`else
  localparam bit CONV = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, in_valid, out_ready;
  logic [31:0] in_data;

  fir_requant_decim_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b4 ();
  fir_requant_decim_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b1 ();

  assign b4.in_valid  = in_valid;
  assign b4.in_data   = in_data;
  assign b4.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;

  logic [3:0] lvl4, lvl1;
  logic       sat4, sat1, ovf4, ovf1;

  fir_requant_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .bus(b4), .clr_flags(clr),
    .fifo_level(lvl4), .sat_flag(sat4), .ovf_flag(ovf4));

  fir_requant_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .clr_flags(clr),
    .fifo_level(lvl1), .sat_flag(sat1), .ovf_flag(ovf1));

  // index 0 = DECIM 4 instance, index 1 = DECIM 1 instance
  logic        ov [2];
  logic [15:0] od [2];
  logic [3:0]  lv [2];
  logic        sf [2];
  logic        of [2];
  assign ov[0] = b4.out_valid; assign ov[1] = b1.out_valid;
  assign od[0] = b4.out_data;  assign od[1] = b1.out_data;
  assign lv[0] = lvl4;         assign lv[1] = lvl1;
  assign sf[0] = sat4;         assign sf[1] = sat1;
  assign of[0] = ovf4;         assign of[1] = ovf1;

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------ reference model
  int          decim_of [2] = '{4, 1};
  int unsigned mcnt [2];
  int          fq [2][$];
  bit          pv [2][2];
  int          pval [2][2];
  bit          psat [2][2];
  bit          msat [2];
  bit          movf [2];

  function automatic longint ref_round(longint x);
    longint sc, half, fl, frac;
    sc   = longint'(1) << SHIFT;
    half = sc / 2;
    fl   = x / sc;
    if ((x % sc) != 0 && x < 0) fl = fl - 1;
    frac = x - fl * sc;
    if (frac > half) return fl + 1;
    if (frac < half) return fl;
    if (CONV && (fl % 2 == 0)) return fl;
    return fl + 1;
  endfunction

  function automatic int ref_out(longint x);
    longint r;
    r = ref_round(x);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic bit ref_sat(longint x);
    longint r;
    r = ref_round(x);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      fq[d].delete();
      msat[d] = 0;
      movf[d] = 0;
      for (int k = 0; k < 2; k++) begin
        pv[d][k] = 0; pval[d][k] = 0; psat[d][k] = 0;
      end
    end
  endfunction

  // One clock: advance the model with the inputs present at the edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    bit     pop, ovf_ev, keep;
    longint x;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_clear();
      end else begin
        pop    = (fq[d].size() > 0) && out_ready;
        ovf_ev = pv[d][1] && (fq[d].size() == DEPTH) && !pop;
        if (pv[d][1] && psat[d][1]) msat[d] = 1;
        else if (clr)               msat[d] = 0;
        if (ovf_ev)                 movf[d] = 1;
        else if (clr)               movf[d] = 0;
        if (pop) void'(fq[d].pop_front());
        if (pv[d][1] && !ovf_ev) fq[d].push_back(pval[d][1]);
        pv[d][1] = pv[d][0]; pval[d][1] = pval[d][0]; psat[d][1] = psat[d][0];
        keep = 0;
        if (in_valid) begin
          keep    = (mcnt[d] == 0);
          mcnt[d] = (mcnt[d] + 1) % decim_of[d];
        end
        x = longint'($signed(in_data));
        pv[d][0]   = keep;
        pval[d][0] = keep ? ref_out(x) : 0;
        psat[d][0] = keep ? ref_sat(x) : 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1; in_valid = 0; out_ready = 0; clr = 0; in_data = '0;
    model_clear();
    tick();
    rst = 0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    apply_reset();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %0b expected 0", d, ov[d]); end
      n_tests++; if (od[d] !== 16'h0) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %0h expected 0", d, od[d]); end
      n_tests++; if (lv[d] !== 4'd0) begin n_fail++; $display("FAIL reset_level[%0d]: got %0d expected 0", d, lv[d]); end
      n_tests++; if ({sf[d], of[d]} !== 2'b00) begin n_fail++; $display("FAIL reset_flags[%0d]: got %0b%0b expected 00", d, sf[d], of[d]); end
    end
  endtask

  task automatic test_reset_midstream();
    int exp_first;
    apply_reset();
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_data = (k == 0) ? 32'h7FFF_FFFF : 32'($urandom_range(0, 1000000));
      tick();
    end
    in_valid = 0;
    tick(); tick();
    n_tests++; if (lv[1] !== 4'd5) begin n_fail++; $display("FAIL midreset_prefill_level: got %0d expected 5", lv[1]); end
    #2 rst = 1;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if ({ov[d], od[d], lv[d], sf[d], of[d]} !== 23'h0) begin
        n_fail++; $display("FAIL midreset_clear[%0d]: got v=%0b d=%0h l=%0d s=%0b o=%0b expected all 0", d, ov[d], od[d], lv[d], sf[d], of[d]);
      end
    end
    @(negedge clk);
    tick();
    rst = 0;
    in_valid = 1; in_data = 32'd1_000_000;
    exp_first = ref_out(longint'(1_000_000));
    tick();
    in_valid = 0;
    tick(); tick();
    n_tests++; if (ov[0] !== 1'b1 || od[0] !== 16'(exp_first)) begin
      n_fail++; $display("FAIL midreset_first_kept: got v=%0b d=%0d expected v=1 d=%0d", ov[0], $signed(od[0]), exp_first);
    end
  endtask

  task automatic test_decimation();
    int first_at, pulses;
    apply_reset();
    out_ready = 1; in_valid = 1; in_data = 32'd3276800;
    first_at = -1; pulses = 0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      n_tests++; if (ov[0] !== (fq[0].size() > 0)) begin n_fail++; $display("FAIL decim_valid t=%0d: got %0b expected %0b", t, ov[0], fq[0].size() > 0); end
      if (ov[0] === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = t;
        n_tests++; if (od[0] !== 16'd100) begin n_fail++; $display("FAIL decim_data t=%0d: got %0d expected 100", t, $signed(od[0])); end
      end
    end
    in_valid = 0;
    n_tests++; if (first_at !== 3) begin n_fail++; $display("FAIL decim_latency: got first valid after edge %0d expected 3", first_at); end
    n_tests++; if (pulses !== 6) begin n_fail++; $display("FAIL decim_pulses: got %0d expected 6", pulses); end
  endtask

  int rnd_in  [7] = '{16384, -16384, 49152, -49152, 3276800, 32767, -32769};
`ifdef FIR_REQUANT_CONV_ROUND_EN
  int rnd_exp [7] = '{0, 0, 2, -2, 100, 1, -1};
`else
  int rnd_exp [7] = '{1, 0, 2, -1, 100, 1, -1};
`endif

  task automatic test_rounding();
    apply_reset();
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1; in_data = 32'(rnd_in[k]);
      tick();
      in_valid = 0;
      tick(); tick();
      n_tests++; if (ov[1] !== 1'b1 || od[1] !== 16'(rnd_exp[k])) begin
        n_fail++; $display("FAIL round in=%0d: got v=%0b d=%0d expected v=1 d=%0d", rnd_in[k], ov[1], $signed(od[1]), rnd_exp[k]);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1;
    in_valid = 1; in_data = 32'h7FFF_FFFF; tick();
    in_valid = 0; tick(); tick();
    n_tests++; if (od[1] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_data: got %0h expected 7fff", od[1]); end
    n_tests++; if (sf[1] !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag: got %0b expected 1", sf[1]); end
    tick();
    in_valid = 1; in_data = 32'h8000_0000; tick();
    in_valid = 0; tick(); tick();
    n_tests++; if (od[1] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_data: got %0h expected 8000", od[1]); end
    tick();
    clr = 1; tick(); clr = 0;
    n_tests++; if (sf[1] !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0b expected 0", sf[1]); end
    in_valid = 1; in_data = 32'h7FFF_FFFF; tick();
    in_valid = 0; tick();
    clr = 1; tick(); clr = 0;
    n_tests++; if (sf[1] !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %0b expected 1", sf[1]); end
    clr = 1; tick(); clr = 0;
    n_tests++; if (sf[1] !== 1'b0 || of[1] !== 1'b0) begin n_fail++; $display("FAIL sat_clear2: got s=%0b o=%0b expected 0 0", sf[1], of[1]); end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    out_ready = 0; in_valid = 1;
    for (int k = 1; k <= 10; k++) begin in_data = 32'(k * 32768); tick(); end
    in_valid = 0;
    tick(); tick();
    n_tests++; if (lv[1] !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", lv[1]); end
    n_tests++; if (of[1] !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %0b expected 1", of[1]); end
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      n_tests++; if (ov[1] !== 1'b1 || od[1] !== 16'(k)) begin
        n_fail++; $display("FAIL full_drain[%0d]: got v=%0b d=%0d expected v=1 d=%0d", k, ov[1], $signed(od[1]), k);
      end
      tick();
    end
    n_tests++; if (ov[1] !== 1'b0 || lv[1] !== 4'd0) begin n_fail++; $display("FAIL full_empty: got v=%0b l=%0d expected 0 0", ov[1], lv[1]); end
    out_ready = 0;
  endtask

  task automatic test_full_push_pop();
    int exp_seq [8] = '{2, 3, 4, 5, 6, 7, 8, 99};
    apply_reset();
    out_ready = 0; in_valid = 1;
    for (int k = 1; k <= 8; k++) begin in_data = 32'(k * 32768); tick(); end
    in_data = 32'(99 * 32768); tick();
    in_valid = 0; tick();
    n_tests++; if (lv[1] !== 4'd8) begin n_fail++; $display("FAIL pp_prefill: got %0d expected 8", lv[1]); end
    out_ready = 1; tick(); out_ready = 0;
    n_tests++; if (lv[1] !== 4'd8) begin n_fail++; $display("FAIL pp_level: got %0d expected 8", lv[1]); end
    n_tests++; if (of[1] !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %0b expected 0", of[1]); end
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      n_tests++; if (ov[1] !== 1'b1 || od[1] !== 16'(exp_seq[k])) begin
        n_fail++; $display("FAIL pp_order[%0d]: got v=%0b d=%0d expected v=1 d=%0d", k, ov[1], $signed(od[1]), exp_seq[k]);
      end
      tick();
    end
    n_tests++; if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %0b expected 0", ov[1]); end
    out_ready = 0;
  endtask

  task automatic test_random();
    int ev;
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       in_data = $urandom;
        1:       in_data = 32'(int'($urandom_range(0, 400)) - 200) * 32'd32768 + 32'd16384;
        default: in_data = 32'(int'($urandom_range(0, 8388608)) - 4194304);
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        ev = (fq[d].size() > 0) ? fq[d][0] : 0;
        n_tests++; if (ov[d] !== (fq[d].size() > 0)) begin n_fail++; $display("FAIL rand_valid[%0d] t=%0d: got %0b expected %0b", d, t, ov[d], fq[d].size() > 0); end
        n_tests++; if (od[d] !== 16'(ev)) begin n_fail++; $display("FAIL rand_data[%0d] t=%0d: got %0d expected %0d", d, t, $signed(od[d]), ev); end
        n_tests++; if (lv[d] !== 4'(fq[d].size())) begin n_fail++; $display("FAIL rand_level[%0d] t=%0d: got %0d expected %0d", d, t, lv[d], fq[d].size()); end
        n_tests++; if (sf[d] !== msat[d] || of[d] !== movf[d]) begin
          n_fail++; $display("FAIL rand_flags[%0d] t=%0d: got s=%0b o=%0b expected s=%0b o=%0b", d, t, sf[d], of[d], msat[d], movf[d]);
        end
      end
    end
    in_valid = 0; out_ready = 0; clr = 0;
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0; out_ready = 0; in_data = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_reset_midstream();
    test_decimation();
    test_rounding();
    test_saturation();
    test_fifo_full();
    test_full_push_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
